// File: rtl/clk_mon_if.sv
// Signal bundle between the clock monitor and its environment.
// half_valid is a one-cycle strobe with no backpressure; half_period holds its value until the next strobe.
interface clk_mon_if #(
    parameter int G_CNT_W = 16
);
    logic               enable;
    logic               clk_in;
    logic               clr_err;
    logic               locked;
    logic               err;
    logic [7:0]         err_cnt;
    logic               stuck;
    logic [G_CNT_W-1:0] half_period;
    logic               half_valid;
    logic [1:0]         state_dbg;

    modport master (
        output enable, clk_in, clr_err,
        input  locked, err, err_cnt, stuck, half_period, half_valid, state_dbg
    );

    modport slave (
        input  enable, clk_in, clr_err,
        output locked, err, err_cnt, stuck, half_period, half_valid, state_dbg
    );
endinterface

// File: rtl/clk_mon.sv
// Clock monitor: measures half periods of an asynchronous clk_in in clk cycles,
// tracks lock, flags out-of-tolerance halves and missing edges.
module clk_mon #(
    parameter int G_HALF_PERIOD_CYC = 10,
    parameter int G_TOL             = 1,
    parameter int G_LOCK_CNT        = 4,
    parameter int G_TIMEOUT         = 64,
    parameter int G_CNT_W           = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    clk_mon_if.slave mon
);
    localparam int                 LO_INT    = (G_HALF_PERIOD_CYC > G_TOL) ? (G_HALF_PERIOD_CYC - G_TOL) : 0;
    localparam logic [G_CNT_W-1:0] TOL_LO    = G_CNT_W'(LO_INT);
    localparam logic [G_CNT_W-1:0] TOL_HI    = G_CNT_W'(G_HALF_PERIOD_CYC + G_TOL);
    localparam logic [G_CNT_W-1:0] TIMEOUT_C = G_CNT_W'(G_TIMEOUT);
    localparam int                 GOOD_W    = $clog2(G_LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0]  LOCK_C    = GOOD_W'(G_LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SYNC    = 2'd1,
        MEASURE = 2'd2,
        LOCKED  = 2'd3
    } state_t;

    state_t             state;
    logic               sync1;
    logic               sync2;
    logic               sync3;
    logic               edge_stb;
    logic [G_CNT_W-1:0] cnt;
    logic [GOOD_W-1:0]  good_cnt;
    logic               locked_q;
    logic               err_q;
    logic [7:0]         err_cnt_q;
    logic               stuck_q;
    logic [G_CNT_W-1:0] half_period_q;
    logic               half_valid_q;

    logic               in_tol;
    logic               measuring;
    logic               timeout_hit;
    logic               new_err;
    logic [GOOD_W-1:0]  good_inc;
    logic [G_CNT_W-1:0] cnt_inc;
    logic [7:0]         err_cnt_inc;

    // Either polarity of clk_in transition marks a half-period boundary.
    assign edge_stb    = sync2 ^ sync3;
    assign in_tol      = (cnt >= TOL_LO) && (cnt <= TOL_HI);
    assign measuring   = (state == MEASURE) || (state == LOCKED);
    assign timeout_hit = measuring && !edge_stb && (cnt >= TIMEOUT_C);
    // Errors only count once locked: a bad half or a lost clock while locked.
    assign new_err     = mon.enable && (state == LOCKED) && ((edge_stb && !in_tol) || timeout_hit);
    assign good_inc    = good_cnt + GOOD_W'(1);
    assign cnt_inc     = (cnt == '1) ? cnt : cnt + G_CNT_W'(1);
    assign err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            sync3         <= 1'b0;
            cnt           <= '0;
            good_cnt      <= '0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
            err_cnt_q     <= 8'd0;
            stuck_q       <= 1'b0;
            half_period_q <= '0;
            half_valid_q  <= 1'b0;
        end else begin
            sync1        <= mon.clk_in;
            sync2        <= sync1;
            sync3        <= sync2;
            half_valid_q <= 1'b0;

            // A new error overrides a coincident clear and restarts the count at one.
            if (new_err) begin
                err_q     <= 1'b1;
                err_cnt_q <= mon.clr_err ? 8'd1 : err_cnt_inc;
            end else if (mon.clr_err) begin
                err_q     <= 1'b0;
                err_cnt_q <= 8'd0;
            end

            if (!mon.enable) begin
                state    <= IDLE;
                locked_q <= 1'b0;
                stuck_q  <= 1'b0;
                cnt      <= '0;
                good_cnt <= '0;
            end else begin
                cnt <= edge_stb ? G_CNT_W'(1) : cnt_inc;
                if (edge_stb) begin
                    stuck_q <= 1'b0;
                end

                case (state)
                    IDLE: begin
                        state <= SYNC;
                    end
                    SYNC: begin
                        // First edge only aligns the counter; the partial interval is dropped.
                        if (edge_stb) begin
                            state <= MEASURE;
                        end
                    end
                    MEASURE: begin
                        if (edge_stb) begin
                            half_period_q <= cnt;
                            half_valid_q  <= 1'b1;
                            if (!in_tol) begin
                                good_cnt <= '0;
                            end else if (good_inc == LOCK_C) begin
                                good_cnt <= '0;
                                locked_q <= 1'b1;
                                state    <= LOCKED;
                            end else begin
                                good_cnt <= good_inc;
                            end
                        end else if (timeout_hit) begin
                            stuck_q  <= 1'b1;
                            good_cnt <= '0;
                            state    <= SYNC;
                        end
                    end
                    LOCKED: begin
                        if (edge_stb) begin
                            half_period_q <= cnt;
                            half_valid_q  <= 1'b1;
                            if (!in_tol) begin
                                locked_q <= 1'b0;
                                good_cnt <= '0;
                                state    <= MEASURE;
                            end
                        end else if (timeout_hit) begin
                            stuck_q  <= 1'b1;
                            locked_q <= 1'b0;
                            good_cnt <= '0;
                            state    <= SYNC;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign mon.locked      = locked_q;
    assign mon.err         = err_q;
    assign mon.err_cnt     = err_cnt_q;
    assign mon.stuck       = stuck_q;
    assign mon.half_period = half_period_q;
    assign mon.half_valid  = half_valid_q;
    assign mon.state_dbg   = state;
endmodule

// File: tb/tb_clk_mon.sv
// Bench for clk_mon: clk_in is driven as a sequence of half periods; an event-level
// model predicts each half_valid report and the status flags between edges.
module tb_clk_mon;
    localparam int HALF    = 10;
    localparam int TOL     = 1;
    localparam int LOCK_N  = 4;
    localparam int TIMEOUT = 64;
    localparam int CNT_W   = 16;
    localparam int EXP_W   = CNT_W + 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    clk_mon_if #(.G_CNT_W(CNT_W)) mif ();

    clk_mon #(
        .G_HALF_PERIOD_CYC(HALF),
        .G_TOL(TOL),
        .G_LOCK_CNT(LOCK_N),
        .G_TIMEOUT(TIMEOUT),
        .G_CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .mon(mif)
    );

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_exp;
    int n_checks = 0;
    int n_errors = 0;

    // Reference model: what the monitor should believe after each clk_in edge.
    bit m_synced = 0;
    bit m_locked = 0;
    bit m_err    = 0;
    bit m_stuck  = 0;
    int m_good      = 0;
    int m_err_cnt   = 0;
    int m_last_hp   = 0;
    int m_tot_err   = 0;
    int last_gap    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_synced = 0; m_locked = 0; m_err = 0; m_stuck = 0;
        m_good = 0; m_err_cnt = 0; m_last_hp = 0;
    endtask

    task automatic model_error(input bit clr);
        m_err = 1;
        m_tot_err++;
        if (clr) m_err_cnt = 1;
        else if (m_err_cnt < 255) m_err_cnt++;
    endtask

    // Called when clk_in toggles: judges the gap that just ended.
    task automatic model_edge(input bit clr);
        bit measured;
        bit good;
        bit fault;
        int dev;
        measured = m_synced;
        fault = 0;
        if (!m_synced) begin
            m_synced = 1;
            m_good   = 0;
        end else begin
            dev  = (last_gap > HALF) ? last_gap - HALF : HALF - last_gap;
            good = (dev <= TOL);
            if (m_locked) begin
                if (!good) begin
                    fault = 1; m_locked = 0; m_good = 0;
                end
            end else if (good) begin
                m_good++;
                if (m_good == LOCK_N) begin
                    m_locked = 1; m_good = 0;
                end
            end else begin
                m_good = 0;
            end
        end
        m_stuck = 0;
        if (fault) model_error(clr);
        else if (clr) begin m_err = 0; m_err_cnt = 0; end
        if (measured) begin
            m_last_hp = last_gap;
            exp_q.push_back({CNT_W'(last_gap), m_locked, m_err, 8'(m_err_cnt)});
        end
    endtask

    // ---------------- driver ----------------
    // Toggle clk_in now, then hold for g cycles; clr_cyc=2 lines clr_err up with
    // the processing of this toggle, clr_cyc>2 pulses it mid-gap, 0 means none.
    task automatic half(input int g, input int clr_cyc);
        model_edge(clr_cyc == 2);
        mif.clk_in = ~mif.clk_in;
        for (int i = 1; i <= g; i++) begin
            @(negedge clk);
            mif.clr_err = (i == clr_cyc);
        end
        if (clr_cyc > 2) begin m_err = 0; m_err_cnt = 0; end
        if (m_synced && g > TIMEOUT) begin
            if (m_locked) model_error(0);
            m_locked = 0; m_synced = 0; m_good = 0; m_stuck = 1;
        end
        check("stuck", mif.stuck, m_stuck);
        check("locked", mif.locked, m_locked);
        check("err", mif.err, m_err);
        check("err_cnt", mif.err_cnt, m_err_cnt);
        last_gap = g;
    endtask

    task automatic relock();
        for (int k = 0; k < 12 && !m_locked; k++)
            half($urandom_range(HALF - TOL, HALF + TOL), 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && mif.half_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL half_valid_unexpected actual=%0d required=none", mif.half_period);
            end else begin
                mon_exp = exp_q.pop_front();
                check("half_report", {mif.half_period, mif.locked, mif.err, mif.err_cnt}, mon_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int g;
        int c;
        int iters;
        rst_n = 1'b0;
        mif.enable = 1'b0;
        mif.clk_in = 1'b0;
        mif.clr_err = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_locked", mif.locked, 0);
        check("rst_err", mif.err, 0);
        check("rst_err_cnt", mif.err_cnt, 0);
        check("rst_stuck", mif.stuck, 0);
        check("rst_half_period", mif.half_period, 0);
        check("rst_half_valid", mif.half_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        mif.enable = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal 10/10 clock: sync edge plus four good halves reaches lock.
        repeat (7) half(10, 0);
        check("nominal_locked", mif.locked, 1);
        check("nominal_err", mif.err, 0);

        // One long half while locked, then recovery.
        half(13, 0);
        repeat (6) half(10, 0);
        check("relock_after_13", mif.locked, 1);
        check("err_sticky", mif.err, 1);
        check("err_cnt_one", mif.err_cnt, 1);

        // Edge-of-tolerance jitter keeps lock; 8 breaks it.
        repeat (8) begin half(9, 0); half(11, 0); end
        check("jitter_err_cnt", mif.err_cnt, 1);
        half(8, 0);
        half(10, 0);
        check("short_half_err_cnt", mif.err_cnt, 2);
        relock();

        // Lost clock while locked, then restart.
        half(100, 0);
        check("stuck_set", mif.stuck, 1);
        check("stuck_err_cnt", mif.err_cnt, 3);
        relock();
        check("stuck_cleared", mif.stuck, 0);
        check("stuck_relock", mif.locked, 1);

        // clr_err coinciding with a bad half, then clr_err alone.
        half(13, 0);
        half(10, 2);
        check("clr_vs_err_cnt", mif.err_cnt, 1);
        relock();
        half(10, 5);
        check("clr_alone_err", mif.err, 0);
        check("clr_alone_err_cnt", mif.err_cnt, 0);

        // Enable dropped while locked.
        relock();
        mif.enable = 1'b0;
        m_locked = 0; m_stuck = 0; m_synced = 0; m_good = 0;
        @(negedge clk);
        check("disable_locked", mif.locked, m_locked);
        check("disable_err_cnt", mif.err_cnt, m_err_cnt);
        check("disable_half_period", mif.half_period, m_last_hp);
        repeat (3) @(negedge clk);
        mif.enable = 1'b1;
        repeat (2) @(negedge clk);
        relock();

        // Random half periods with occasional clears and stalls.
        for (int n = 0; n < 200; n++) begin
            c = $urandom_range(0, 39);
            if (c == 0) g = 100;
            else if (c < 8) g = $urandom_range(3, 40);
            else g = $urandom_range(HALF - TOL, HALF + TOL);
            c = 0;
            if (g >= 7 && g <= TIMEOUT && $urandom_range(0, 9) == 0)
                c = ($urandom_range(0, 1) == 1) ? 2 : 5;
            half(g, c);
        end

        // Drive enough faults to saturate the error counter.
        m_tot_err = 0;
        iters = 0;
        while (m_tot_err < 300 && iters < 5000) begin
            if (m_locked) half($urandom_range(3, 7), 0);
            else half($urandom_range(HALF - TOL, HALF + TOL), 0);
            iters++;
        end
        check("err_cnt_saturated", mif.err_cnt, 255);

        // Asynchronous reset in the middle of a locked period.
        relock();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_locked", mif.locked, 0);
        check("async_rst_err", mif.err, 0);
        check("async_rst_err_cnt", mif.err_cnt, 0);
        check("async_rst_half_period", mif.half_period, 0);
        mif.clk_in = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        relock();
        check("post_rst_locked", mif.locked, 1);
        repeat (4) @(negedge clk);

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #3000000;
        n_errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/clk_mon.md
CLK_MON -- requirements
Module: clk_mon

Interface
REQ-001 SHALL have parameter G_HALF_PERIOD_CYC, default 10: nominal half period of the monitored clock, in clk cycles.
REQ-002 SHALL have parameter G_TOL, default 1: allowed deviation in clk cycles, applied to each measured half period.
REQ-003 SHALL have parameter G_LOCK_CNT, default 4: number of consecutive in-tolerance half periods needed to assert lock.
REQ-004 SHALL have parameter G_TIMEOUT, default 64: count at which a missing edge is declared stuck; must exceed G_HALF_PERIOD_CYC+G_TOL.
REQ-005 SHALL have parameter G_CNT_W, default 16: width of the half-period counter.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 enable  in  1  monitor enable.
REQ-009 clk_in  in  1  monitored clock, asynchronous to clk, treated as data.
REQ-010 clr_err  in  1  synchronous clear of err and err_cnt.
REQ-011 locked  out  1  high while clk_in is in tolerance.
REQ-012 err  out  1  sticky error flag.
REQ-013 err_cnt  out  8  error count, saturating.
REQ-014 stuck  out  1  no clk_in edge seen within G_TIMEOUT.
REQ-015 half_period  out  G_CNT_W  last measured half period.
REQ-016 half_valid  out  1  one-cycle strobe when half_period updates.

Function
REQ-017 clk_in SHALL pass through a 2-flop synchronizer; any edge (rise or fall) SHALL be detected by comparing the second flop with a third flop. An edge sampled at clk edge N yields the edge strobe in cycle N+2.
REQ-018 FSM states SHALL be IDLE, SYNC, MEASURE and LOCKED.
  - IDLE when enable=0.
  - IDLE->SYNC when enable=1.
REQ-019 The counter SHALL load 1 on an edge strobe, increment otherwise, and saturate at 2^G_CNT_W-1.
REQ-020 In SYNC, the first edge SHALL only restart the counter (the partial interval is discarded); the FSM then moves to MEASURE. No half_valid pulse is issued.
REQ-021 In MEASURE or LOCKED, each edge SHALL:
  - load half_period with the pre-edge count;
  - pulse half_valid for one cycle;
  - classify the interval as good when |count-G_HALF_PERIOD_CYC| <= G_TOL.
REQ-022 In MEASURE:
  - a good interval increments the good-count;
  - when the good-count reaches G_LOCK_CNT, go to LOCKED and set locked=1 in the next cycle;
  - a bad interval zeroes the good-count and does not set err.
REQ-023 A bad interval in LOCKED SHALL:
  - set err=1 and increment err_cnt;
  - clear locked;
  - zero the good-count;
  - move to MEASURE.
REQ-024 When the count reaches G_TIMEOUT in MEASURE or LOCKED:
  - stuck=1, locked=0, go to SYNC;
  - if the FSM was in LOCKED, also set err and increment err_cnt.
  - stuck SHALL clear on the next edge strobe.
REQ-025 err_cnt SHALL saturate at 255.
REQ-026 clr_err SHALL zero err and err_cnt. If clr_err coincides with a new error, the error SHALL win: err=1, err_cnt=1.
REQ-027 Deasserting enable SHALL, next cycle:
  - go to IDLE;
  - zero locked, stuck, the counter and the good-count;
  - keep err, err_cnt and half_period.

Reset
REQ-028 rst_n=0 SHALL immediately, without a clk edge, force:
  - state=IDLE;
  - all synchronizer flops, counters and outputs to 0 (including err, err_cnt, half_period and half_valid).
REQ-029 After rst_n is released, the block SHALL resume on the first clk rising edge with enable sampled.

Verification
REQ-030 enable=1, clk_in half period 10 clk -> half_valid every 10 cycles with half_period=10; locked=1 after the first edge plus 4 good halves; err=0.
REQ-031 Locked, one half period of 13 -> err=1, err_cnt=1, locked=0; after 4 further halves of 10, locked=1 again, err stays 1.
REQ-032 Half periods alternating 9/11 -> locked=1 is held and err stays 0; a half of 8 while locked -> err_cnt increments.
REQ-033 Locked, clk_in held low -> stuck=1 and locked=0 once the count reaches 64, err_cnt+1; clk_in restarting at 10/10 -> stuck=0 and re-lock.
REQ-034 clr_err pulse in the same cycle as a bad interval -> err=1, err_cnt=1; clr_err alone -> err=0, err_cnt=0. Forcing 300 errors -> err_cnt=255.
REQ-035 rst_n=0 mid-lock, between clk edges -> locked, err, err_cnt and half_period are 0 at once; enable toggled 1->0 while locked -> locked=0 next cycle with err_cnt retained.
